// File: rtl/muldiv_if.sv
// EX-stage mul/div request/result bundle between the pipeline and muldiv_ctrl.
// The pipeline side is the master; the sequencer is the slave.
interface muldiv_if;
  logic [7:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush_i;
  logic        stall_o;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output alucontrol, a, b, flush_i,
    input  stall_o, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  alucontrol, a, b, flush_i,
    output stall_o, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with a one-cycle HI/LO write pulse.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when |divisor| > |dividend|.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [7:0]  counter;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] prod;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        is_mul;
  logic        is_div;
  logic        sgn_div;
  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fit;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic        early;

  assign is_mul  = (bus.alucontrol == EXE_MULT_OP) || (bus.alucontrol == EXE_MULTU_OP);
  assign is_div  = (bus.alucontrol == EXE_DIV_OP)  || (bus.alucontrol == EXE_DIVU_OP);
  assign sgn_div = (bus.alucontrol == EXE_DIV_OP);
  assign start   = (state == IDLE) && (is_mul || is_div) && !bus.flush_i;

  assign a_mag = cond_neg(bus.a, sgn_div && bus.a[31]);
  assign b_mag = cond_neg(bus.b, sgn_div && bus.b[31]);

  assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // One restoring step: shift in the next dividend bit, keep the subtraction if it fits.
  assign shifted = {rem, quo[31]};
  assign trial   = shifted - {1'b0, dvs};
  assign fit     = !trial[32];
  assign rem_nx  = fit ? trial[31:0] : shifted[31:0];
  assign quo_nx  = {quo[30:0], fit};

`ifdef DIV_EARLY_EXIT_EN
  assign early = (b_mag > a_mag);
`else
  assign early = 1'b0;
`endif

  assign bus.stall_o = start || (((state == MUL) || (state == DIV)) && !bus.flush_i);
  assign bus.hilo_we = (state == DONE) && !bus.flush_i;

  // Operand and iteration datapath; no reset needed, always reloaded at start.
  always_ff @(posedge clk) begin
    if (start) begin
      prod  <= (bus.alucontrol == EXE_MULT_OP) ? 64'(prod_s) : prod_u;
      rem   <= 32'd0;
      quo   <= a_mag;
      dvs   <= b_mag;
      neg_q <= sgn_div && (bus.a[31] ^ bus.b[31]);
      neg_r <= sgn_div && bus.a[31];
    end else if (state == DIV) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end

  // Control FSM; results are written to hi_o/lo_o only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= 8'd0;
      bus.hi_o   <= 32'd0;
      bus.lo_o   <= 32'd0;
    end else if (bus.flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            counter <= 8'd0;
            if (is_mul) begin
              state <= MUL;
            end else if (bus.b == 32'd0) begin
              bus.hi_o <= bus.a;
              bus.lo_o <= 32'hFFFF_FFFF;
              state    <= DONE;
            end else if (early) begin
              bus.hi_o <= bus.a;
              bus.lo_o <= 32'd0;
              state    <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (counter == 8'(MUL_CYCLES - 1)) begin
            bus.hi_o <= prod[63:32];
            bus.lo_o <= prod[31:0];
            state    <= DONE;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        DIV: begin
          if (counter == 8'(DIV_ITERS - 1)) begin
            bus.hi_o <= cond_neg(rem_nx, neg_r);
            bus.lo_o <= cond_neg(quo_nx, neg_q);
            state    <= DONE;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
